// File: rtl/t_inst_seq_pkg.sv
// t_inst_seq_pkg
// Shared types and helpers for the instance-connectivity sequencer:
//   state_t    - run-control states
//   ERR_CNT_W  - width of the saturating error counter
//   lane_val   - stimulus value of lane j in vector k, truncated to w bits
package t_inst_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int ERR_CNT_W = 8;

  // Pattern is (seed + k*n + j) mod 2^w; computed wide so the wrap is exact.
  function automatic logic [31:0] lane_val(input logic [31:0] seed,
                                           input int unsigned k,
                                           input int unsigned j,
                                           input int unsigned n,
                                           input int unsigned w);
    logic [63:0] sum;
    logic [63:0] mask;
    sum  = 64'(seed) + 64'(k) * 64'(n) + 64'(j);
    mask = (64'd1 << w) - 64'd1;
    return 32'(sum & mask);
  endfunction

endpackage

// File: rtl/t_inst_dly_pipe.sv
// t_inst_dly_pipe
// Fixed-latency shift register used to line up the expected registered echo.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, clears every stage
//   din   - data entering stage 0 (caller packs a valid bit in the MSB)
//   dout  - data leaving the last stage, DEPTH cycles after din
module t_inst_dly_pipe #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/t_inst_seq_chk.sv
// t_inst_seq_chk
// Self-checking stimulus/response sequencer placed beside a DUT instance.
// Drives NVEC vectors of N lanes x W bits, checks a combinational echo and a
// DELAY-cycle registered echo, watches a guard bus, and reports pass/fail.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   start         - pulse; starts a run from IDLE or DONE
//   stim_o        - stimulus bus, lane 0 in the MSBs
//   comb_i        - combinational echo of stim_o
//   dly_i         - echo of stim_o delayed DELAY cycles
//   guard_i       - guard bits, any 1 while busy is an error
//   busy          - run in progress (DRIVE or DRAIN)
//   passed/failed - run result, valid in DONE
//   err_count     - saturating error count
//   err_lane      - lowest mismatching lane of the first mismatch cycle
//   err_lane_vld  - err_lane holds a capture
module t_inst_seq_chk
  import t_inst_seq_pkg::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 5,
  parameter int unsigned DELAY = 1,
  parameter int unsigned NVEC  = 4,
  parameter logic [31:0] SEED  = 32'h0a,
  parameter int unsigned G     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic [N*W-1:0]       stim_o,
  input  logic [N*W-1:0]       comb_i,
  input  logic [N*W-1:0]       dly_i,
  input  logic [G-1:0]         guard_i,
  output logic                 busy,
  output logic                 passed,
  output logic                 failed,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [3:0]           err_lane,
  output logic                 err_lane_vld
);

  localparam int BW = N * W;
  localparam int KW = $clog2(NVEC + 1);
  localparam int DW = $clog2(DELAY + 1);
  localparam logic [KW-1:0] K_LAST = KW'(NVEC - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DELAY - 1);

  state_t         state, state_nxt;
  logic [KW-1:0]  k;
  logic [DW-1:0]  dcnt;
  logic [BW:0]    pipe_out;
  logic [N-1:0]   comb_mis, dly_mis;
  logic           comb_err, dly_err, guard_err, launch;
  logic [3:0]     lane_sel;
  logic [ERR_CNT_W:0] cnt_sum;

  function automatic logic [BW-1:0] make_vec(input int unsigned kk);
    logic [BW-1:0] v;
    v = '0;
    for (int j = 0; j < N; j++) v[(N-j)*W-1 -: W] = W'(lane_val(SEED, kk, j, N, W));
    return v;
  endfunction

  function automatic logic [3:0] lowest_lane(input logic [N-1:0] m);
    logic [3:0] r;
    r = '0;
    for (int j = N - 1; j >= 0; j--) if (m[j]) r = 4'(j);
    return r;
  endfunction

  assign launch = ((state == IDLE) || (state == DONE)) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start)          state_nxt = DRIVE;
      DRIVE:      if (k == K_LAST)    state_nxt = DRAIN;
      DRAIN:      if (dcnt == D_LAST) state_nxt = DONE;
      default:                        state_nxt = IDLE;
    endcase
  end

  // stim_o is loaded one cycle ahead so vector k is on the bus during DRIVE cycle k;
  // after the last vector it simply holds through DRAIN and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k      <= '0;
      dcnt   <= '0;
      stim_o <= '0;
    end else if (launch) begin
      k      <= '0;
      dcnt   <= '0;
      stim_o <= make_vec(0);
    end else if (state == DRIVE && k != K_LAST) begin
      k      <= k + KW'(1);
      stim_o <= make_vec(32'(k) + 32'd1);
    end else if (state == DRAIN) begin
      dcnt   <= dcnt + DW'(1);
    end
  end

  // The MSB tags which pipe entries came from DRIVE cycles, so only those are compared.
  t_inst_dly_pipe #(
    .DEPTH (DELAY),
    .WIDTH (BW + 1)
  ) u_dly_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({state == DRIVE, stim_o}),
    .dout  (pipe_out)
  );

  always_comb begin
    comb_mis = '0;
    dly_mis  = '0;
    for (int j = 0; j < N; j++) begin
      comb_mis[j] = comb_i[(N-j)*W-1 -: W] != stim_o[(N-j)*W-1 -: W];
      dly_mis[j]  = dly_i[(N-j)*W-1 -: W]  != pipe_out[(N-j)*W-1 -: W];
    end
  end

  assign busy      = (state == DRIVE) || (state == DRAIN);
  assign comb_err  = (state == DRIVE) && (|comb_mis);
  assign dly_err   = busy && pipe_out[BW] && (|dly_mis);
  assign guard_err = busy && (|guard_i);
  assign lane_sel  = comb_err ? lowest_lane(comb_mis) : lowest_lane(dly_mis);
  assign cnt_sum   = {1'b0, err_count}
                   + {{ERR_CNT_W{1'b0}}, comb_err}
                   + {{ERR_CNT_W{1'b0}}, dly_err}
                   + {{ERR_CNT_W{1'b0}}, guard_err};

  // Count saturates at all-ones; the first mismatching cycle's lane is latched once per run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count    <= '0;
      err_lane     <= '0;
      err_lane_vld <= 1'b0;
    end else if (launch) begin
      err_count    <= '0;
      err_lane     <= '0;
      err_lane_vld <= 1'b0;
    end else if (busy) begin
      err_count <= cnt_sum[ERR_CNT_W] ? '1 : cnt_sum[ERR_CNT_W-1:0];
      if (!err_lane_vld && (comb_err || dly_err)) begin
        err_lane     <= lane_sel;
        err_lane_vld <= 1'b1;
      end
    end
  end

  assign passed = (state == DONE) && (err_count == '0);
  assign failed = (state == DONE) && (err_count != '0);

endmodule

// File: tb/tb_t_inst_seq_chk.sv
// tb_t_inst_seq_chk
// Bench for t_inst_seq_chk: three instances (loopback/corruption, saturation,
// pattern wrap), a directed table, a randomized run set scored by a run-level model.
module tb_t_inst_seq_chk;

  localparam int NA  = 5;
  localparam int DA  = 2;
  localparam int NVA = 4;
  localparam int CYA = NVA + DA;

  typedef struct {
    int         c_cyc;
    int         c_lane;
    int         d_cyc;
    int         d_lane;
    logic [7:0] g_val;
    int         g_first;
    int         g_n;
    int         exp_cnt;
    int         exp_lane;
    bit         exp_vld;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // instance A: W=8 N=5 DELAY=2 NVEC=4
  logic        start_a;
  logic [39:0] stim_a, comb_a, dly_a, cflip, dflip, q1_a, q2_a;
  logic [7:0]  guard_a, err_count_a;
  logic [3:0]  err_lane_a;
  logic        busy_a, passed_a, failed_a, err_lane_vld_a;
  logic [39:0] cf [CYA];
  logic [39:0] df [CYA];
  logic [7:0]  gv [CYA];
  logic [39:0] lit_a [NVA];

  assign comb_a = stim_a ^ cflip;
  assign dly_a  = q2_a ^ dflip;
  always @(posedge clk) begin
    q1_a <= stim_a;
    q2_a <= q1_a;
  end

  t_inst_seq_chk #(.W(8), .N(5), .DELAY(2), .NVEC(4), .SEED(32'h0a), .G(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim_o(stim_a), .comb_i(comb_a),
    .dly_i(dly_a), .guard_i(guard_a), .busy(busy_a), .passed(passed_a),
    .failed(failed_a), .err_count(err_count_a), .err_lane(err_lane_a),
    .err_lane_vld(err_lane_vld_a));

  // instance S: saturation, NVEC=200
  logic        start_s, busy_s, passed_s, failed_s, err_lane_vld_s;
  logic [39:0] stim_s, comb_s, dly_s;
  logic [7:0]  guard_s, err_count_s;
  logic [3:0]  err_lane_s;
  assign comb_s  = ~stim_s;
  assign dly_s   = '0;
  assign guard_s = 8'hff;

  t_inst_seq_chk #(.W(8), .N(5), .DELAY(1), .NVEC(200), .SEED(32'h0a), .G(8)) dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .stim_o(stim_s), .comb_i(comb_s),
    .dly_i(dly_s), .guard_i(guard_s), .busy(busy_s), .passed(passed_s),
    .failed(failed_s), .err_count(err_count_s), .err_lane(err_lane_s),
    .err_lane_vld(err_lane_vld_s));

  // instance W: wrap, SEED=fe N=4 NVEC=1 DELAY=1
  logic        start_w, busy_w, passed_w, failed_w, err_lane_vld_w;
  logic [31:0] stim_w, q_w;
  logic [7:0]  guard_w, err_count_w;
  logic [3:0]  err_lane_w;
  assign guard_w = '0;
  always @(posedge clk) q_w <= stim_w;

  t_inst_seq_chk #(.W(8), .N(4), .DELAY(1), .NVEC(1), .SEED(32'hfe), .G(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start_w), .stim_o(stim_w), .comb_i(stim_w),
    .dly_i(q_w), .guard_i(guard_w), .busy(busy_w), .passed(passed_w),
    .failed(failed_w), .err_count(err_count_w), .err_lane(err_lane_w),
    .err_lane_vld(err_lane_vld_w));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] lane_flip(input int lane);
    return 40'd1 << ((NA - 1 - lane) * 8);
  endfunction

  function automatic int lowest_lane(input logic [39:0] x);
    for (int j = 0; j < NA; j++) begin
      logic [39:0] s;
      s = x >> ((NA - 1 - j) * 8);
      if (s[7:0] != 8'h00) return j;
    end
    return -1;
  endfunction

  // Run-level model: per-cycle error tally from the injected corruptions.
  function automatic void model(output int cnt, output int lane, output bit vld);
    cnt = 0; lane = 0; vld = 0;
    for (int t = 0; t < CYA; t++) begin
      int e, cl, dl;
      e = 0; cl = -1; dl = -1;
      if (t < NVA && cf[t] != 0) begin e++; cl = lowest_lane(cf[t]); end
      if (t >= DA && df[t] != 0) begin e++; dl = lowest_lane(df[t]); end
      if (gv[t] != 0) e++;
      cnt = (cnt + e > 255) ? 255 : cnt + e;
      if (!vld && cl >= 0)      begin lane = cl; vld = 1; end
      else if (!vld && dl >= 0) begin lane = dl; vld = 1; end
    end
  endfunction

  task automatic clear_arrays();
    for (int t = 0; t < CYA; t++) begin cf[t] = '0; df[t] = '0; gv[t] = '0; end
  endtask

  task automatic apply_stimulus(input string tag);
    int busy_cycles;
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0;
    busy_cycles = 0;
    for (int t = 0; t < CYA; t++) begin
      cflip = cf[t]; dflip = df[t]; guard_a = gv[t];
      check({tag, "_stim"}, stim_a, (t < NVA) ? lit_a[t] : lit_a[NVA-1]);
      if (busy_a) busy_cycles++;
      @(posedge clk); #1;
    end
    cflip = '0; dflip = '0; guard_a = '0;
    check({tag, "_busy_len"}, busy_cycles, CYA);
    check({tag, "_busy_end"}, busy_a, 0);
  endtask

  task automatic check_output(input string tag, input int cnt, input int lane, input bit vld);
    check({tag, "_err_count"}, err_count_a, cnt);
    check({tag, "_err_lane_vld"}, err_lane_vld_a, vld);
    if (vld) check({tag, "_err_lane"}, err_lane_a, lane);
    check({tag, "_passed"}, passed_a, cnt == 0);
    check({tag, "_failed"}, failed_a, cnt != 0);
  endtask

  vec_t tbl [10];

  initial begin
    int cnt, lane, t, nb;
    bit vld;

    lit_a[0] = 40'h0a0b0c0d0e; lit_a[1] = 40'h0f10111213;
    lit_a[2] = 40'h1415161718; lit_a[3] = 40'h191a1b1c1d;
    tbl[0] = '{-1, 0, -1, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[1] = '{ 1, 3, -1, 0, 8'h00, 0, 0, 1, 3, 1};
    tbl[2] = '{-1, 0, -1, 0, 8'h01, 0, 3, 3, 0, 0};
    tbl[3] = '{-1, 0,  2, 4, 8'h00, 0, 0, 1, 4, 1};
    tbl[4] = '{ 3, 2,  3, 0, 8'h00, 0, 0, 2, 2, 1};
    tbl[5] = '{-1, 0,  1, 2, 8'h00, 0, 0, 0, 0, 0};
    tbl[6] = '{-1, 0,  5, 1, 8'h00, 0, 0, 1, 1, 1};
    tbl[7] = '{ 4, 0, -1, 0, 8'h00, 0, 0, 0, 0, 0};
    tbl[8] = '{-1, 0, -1, 0, 8'h80, 5, 1, 1, 0, 0};
    tbl[9] = '{ 0, 1,  3, 0, 8'h00, 0, 0, 2, 1, 1};

    start_a = 0; start_s = 0; start_w = 0;
    cflip = '0; dflip = '0; guard_a = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_stim", stim_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_passed", passed_a, 0);
    check("rst_failed", failed_a, 0);
    check("rst_err_count", err_count_a, 0);
    @(negedge clk); rst_n = 1'b1;

    // directed table
    foreach (tbl[i]) begin
      clear_arrays();
      if (tbl[i].c_cyc >= 0) cf[tbl[i].c_cyc] = lane_flip(tbl[i].c_lane);
      if (tbl[i].d_cyc >= 0) df[tbl[i].d_cyc] = lane_flip(tbl[i].d_lane);
      for (int g = tbl[i].g_first; g < tbl[i].g_first + tbl[i].g_n; g++) gv[g] = tbl[i].g_val;
      apply_stimulus($sformatf("tbl%0d", i));
      check_output($sformatf("tbl%0d", i), tbl[i].exp_cnt, tbl[i].exp_lane, tbl[i].exp_vld);
    end

    // reset in the middle of DRIVE, after an error has been logged
    clear_arrays();
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; cflip = lane_flip(0);
    @(posedge clk); #1; cflip = '0;
    @(posedge clk); #1;
    check("mid_pre_err_count", err_count_a, 1);
    #2; rst_n = 1'b0; #1;
    check("mid_stim", stim_a, 0);
    check("mid_busy", busy_a, 0);
    check("mid_passed", passed_a, 0);
    check("mid_failed", failed_a, 0);
    check("mid_err_count", err_count_a, 0);
    check("mid_err_lane", err_lane_a, 0);
    check("mid_err_lane_vld", err_lane_vld_a, 0);
    @(negedge clk); rst_n = 1'b1;
    apply_stimulus("post_rst");
    check_output("post_rst", 0, 0, 0);

    // randomized corruption runs scored by the model
    for (int r = 0; r < 24; r++) begin
      for (int c = 0; c < CYA; c++) begin
        cf[c] = ($urandom_range(0, 3) == 0) ? (40'd1 << $urandom_range(0, 39)) : 40'd0;
        df[c] = ($urandom_range(0, 3) == 0) ? (40'd1 << $urandom_range(0, 39)) : 40'd0;
        gv[c] = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
      end
      model(cnt, lane, vld);
      apply_stimulus($sformatf("rnd%0d", r));
      check_output($sformatf("rnd%0d", r), cnt, lane, vld);
    end

    // saturation: 2 errors in cycle 0, then 3 per cycle -> count 3t-1 until 255
    @(negedge clk); start_s = 1'b1;
    @(posedge clk); #1; start_s = 1'b0;
    t = 0;
    while (busy_s && t < 400) begin
      if (t == 10) check("sat_t10", err_count_s, 29);
      if (t == 85) check("sat_t85", err_count_s, 254);
      if (t == 86) check("sat_t86", err_count_s, 255);
      @(posedge clk); #1; t++;
    end
    check("sat_busy_len", t, 201);
    check("sat_err_count", err_count_s, 255);
    check("sat_failed", failed_s, 1);
    check("sat_err_lane", err_lane_s, 0);

    // wrap and restart; start during DRIVE must not extend the run
    @(negedge clk); start_w = 1'b1;
    @(posedge clk); #1;
    check("wrap_stim", stim_w, 32'hfeff0001);
    nb = 0;
    while (busy_w && nb < 20) begin
      @(posedge clk); #1; start_w = 1'b0; nb++;
    end
    start_w = 1'b0;
    check("wrap_busy_len", nb, 2);
    check("wrap_passed", passed_w, 1);
    @(negedge clk); start_w = 1'b1;
    @(posedge clk); #1; start_w = 1'b0;
    check("restart_passed_clr", passed_w, 0);
    check("restart_busy", busy_w, 1);
    nb = 0;
    while (busy_w && nb < 20) begin
      @(posedge clk); #1; nb++;
    end
    check("restart_busy_len", nb, 2);
    check("restart_passed", passed_w, 1);
    check("restart_failed", failed_w, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/t_inst_seq_chk.md
Name: t_inst_seq_chk

Overview:
- Parametrised self-checking stimulus/response sequencer for instance-connectivity tests.
- Drives N lanes of W-bit stimulus, concatenated with lane 0 in the MSBs, into a device under test (DUT).
- Checks a combinational return path and a DELAY-cycle registered return path, and monitors a guard bus that must stay zero.
- Reports passed/failed plus error statistics; sits at the top of a test harness, beside the DUT instance.

Parameters:
- W, 8: lane width in bits (1..32).
- N, 5: lane count (1..16).
- DELAY, 1: registered-path latency in cycles (1..8).
- NVEC, 4: number of stimulus vectors per run (1..256).
- SEED, 8'h0a: base value of the stimulus pattern, truncated to W bits.
- G, 8: guard bus width.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a run from IDLE or DONE.
- stim_o  out  N*W  stimulus bus to DUT; lane j occupies bits [(N-j)*W-1 -: W].
- comb_i  in  N*W  DUT combinational echo of stim_o.
- dly_i  in  N*W  DUT echo of stim_o delayed DELAY cycles.
- guard_i  in  G  guard bits; any 1 is an error.
- busy  out  1  high in DRIVE or DRAIN.
- passed  out  1  high in DONE with zero errors.
- failed  out  1  high in DONE with nonzero errors.
- err_count  out  8  saturating error count.
- err_lane  out  4  lane of the first lane mismatch.
- err_lane_vld  out  1  err_lane holds a valid capture.

Behaviour:
- Reset (asynchronous, any state): state=IDLE; stim_o=0, busy=0, passed=0, failed=0, err_count=0, err_lane=0, err_lane_vld=0; delay pipe cleared.
  - Reset mid-run aborts the run with no residual state.
- States: IDLE, DRIVE, DRAIN, DONE.
- IDLE/DONE + start=1 → DRIVE next cycle.
  - On entry: vector index k=0; err_count, err_lane_vld, passed and failed cleared.
- start is ignored in DRIVE and DRAIN.
- DRIVE lasts exactly NVEC cycles. In cycle k, stim_o lane j = (SEED + k*N + j) mod 2^W; stim_o is registered.
  - After cycle NVEC-1 → DRAIN.
- DRAIN lasts exactly DELAY cycles.
  - stim_o holds the last vector; it is not compared against comb_i.
  - DRAIN then → DONE.
- DONE: passed = (err_count==0), failed = ~passed. Both hold until start or reset.
- Comb check (DRIVE cycles only): comb_i must equal stim_o in the same cycle.
- Delay check: a valid-tagged pipe of DELAY stages carries stim_o.
  - When the pipe output is valid (cycles DELAY..NVEC+DELAY-1 after DRIVE entry), dly_i must equal the pipe output.
  - This window falls entirely within DRIVE+DRAIN.
- Guard check: |guard_i in any DRIVE or DRAIN cycle is an error.
- Per cycle, err_count += (comb_err + dly_err + guard_err), saturating at 255 (no wrap).
- err_lane capture, on the first cycle with any lane mismatch, while err_lane_vld=0:
  - Capture the lowest mismatching lane.
  - Comb mismatch takes priority over dly mismatch in the same cycle.
  - Set err_lane_vld=1; later mismatches do not overwrite.
- Arithmetic: stimulus lanes truncate to W bits (pattern wraps, e.g. 8'hff → 8'h00).
- k counter width is $clog2(NVEC+1).

Decomposition:
- Package t_inst_seq_pkg:
  - state enum {IDLE, DRIVE, DRAIN, DONE};
  - ERR_CNT_W=8;
  - function lane_val(seed, k, j, W).
- Sub-module t_inst_dly_pipe: parameters DEPTH=DELAY and WIDTH=N*W+1 (data plus valid), async active-low reset, shift register.

Test Plan (defaults unless stated; DELAY=2, NVEC=4 for loopback tests):
- Loopback: comb_i=stim_o; dly_i = stim_o registered twice; start pulse.
  - Response: stim_o = 40'h0a0b0c0d0e, 40'h0f10111213, 40'h1415161718, 40'h191a1b1c1d.
  - busy high 6 cycles; then passed=1, failed=0, err_count=0.
- Corrupt: comb_i lane 3 bit 0 flipped during vector 1 only.
  - Response: err_count=1, err_lane=3, err_lane_vld=1, failed=1.
- Guard: guard_i=8'h01 for 3 DRIVE cycles, echoes correct.
  - Response: err_count=3, err_lane_vld=0, failed=1.
- Saturation: NVEC=200, dly_i tied 0, comb_i inverted, guard_i=8'hff.
  - Response: err_count stops at 255 and does not wrap.
- Reset mid-DRIVE: assert rst_n=0 at vector 2.
  - Response: all outputs 0 immediately, async.
  - After release, start gives a clean passing run.
- Wrap and restart: SEED=8'hfe, N=4, NVEC=1.
  - Response: stim_o = 32'hfeff0001.
  - start in DONE clears passed and reruns; start pulsed during DRIVE is ignored (busy length unchanged).
